// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle processor core: FSM states, opcode
// encodings and instruction-field accessors.
package proc_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_NEXT   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [4:0] OP_MOVSGPR     = 5'b00000;
    localparam logic [4:0] OP_MOV         = 5'b00001;
    localparam logic [4:0] OP_ADD         = 5'b00010;
    localparam logic [4:0] OP_SUB         = 5'b00011;
    localparam logic [4:0] OP_MUL         = 5'b00100;
    localparam logic [4:0] OP_OR          = 5'b00101;
    localparam logic [4:0] OP_AND         = 5'b00110;
    localparam logic [4:0] OP_XOR         = 5'b00111;
    localparam logic [4:0] OP_XNOR        = 5'b01000;
    localparam logic [4:0] OP_NAND        = 5'b01001;
    localparam logic [4:0] OP_NOR         = 5'b01010;
    localparam logic [4:0] OP_NOT         = 5'b01011;
    localparam logic [4:0] OP_STOREREG    = 5'b01100;
    localparam logic [4:0] OP_STOREDIN    = 5'b01101;
    localparam logic [4:0] OP_SENDDOUT    = 5'b01110;
    localparam logic [4:0] OP_LOADREG     = 5'b01111;
    localparam logic [4:0] OP_JUMP        = 5'b10000;
    localparam logic [4:0] OP_JCARRY      = 5'b10001;
    localparam logic [4:0] OP_JNOCARRY    = 5'b10010;
    localparam logic [4:0] OP_JSIGN       = 5'b10011;
    localparam logic [4:0] OP_JNOSIGN     = 5'b10100;
    localparam logic [4:0] OP_JZERO       = 5'b10101;
    localparam logic [4:0] OP_JNOZERO     = 5'b10110;
    localparam logic [4:0] OP_JOVERFLOW   = 5'b10111;
    localparam logic [4:0] OP_JNOOVERFLOW = 5'b11000;
    localparam logic [4:0] OP_HALT        = 5'b11011;

    function automatic logic [4:0] ir_op(input logic [31:0] ir);
        return ir[31:27];
    endfunction

    function automatic logic [4:0] ir_rdst(input logic [31:0] ir);
        return ir[26:22];
    endfunction

    function automatic logic [4:0] ir_rsrc1(input logic [31:0] ir);
        return ir[21:17];
    endfunction

    function automatic logic ir_imm(input logic [31:0] ir);
        return ir[16];
    endfunction

    function automatic logic [4:0] ir_rsrc2(input logic [31:0] ir);
        return ir[15:11];
    endfunction

    function automatic logic [15:0] ir_isrc(input logic [31:0] ir);
        return ir[15:0];
    endfunction

endpackage

// File: rtl/proc_fsm_core_if.sv
// Host-side bus of the core: instruction-memory load port and din/dout stream.
interface proc_fsm_core_if #(
    parameter int DW         = 16,
    parameter int IMEM_DEPTH = 16
);
    logic                          imem_we;
    logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr;
    logic [31:0]                   imem_wdata;
    logic [DW-1:0]                 din;
    logic [DW-1:0]                 dout;
    logic                          dout_valid;

    modport master (
        output imem_we, imem_waddr, imem_wdata, din,
        input  dout, dout_valid
    );

    modport slave (
        input  imem_we, imem_waddr, imem_wdata, din,
        output dout, dout_valid
    );
endinterface

// File: rtl/proc_alu.sv
// Combinational ALU: result, multiply high half and the four condition flags.
module proc_alu
    import proc_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [4:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic [DW-1:0] hi,
    output logic          sign,
    output logic          zero,
    output logic          carry,
    output logic          ovf
);
    logic [DW:0]     sum_s;
    logic [DW-1:0]   diff_s;
    logic [2*DW-1:0] prod_s;

    // Operation select; flags for mul come from the full double-width product
    always_comb begin
        sum_s  = {1'b0, a} + {1'b0, b};
        diff_s = a - b;
        prod_s = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        result = {DW{1'b0}};
        hi     = {DW{1'b0}};
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_MOV:  result = b;
            OP_ADD: begin
                result = sum_s[DW-1:0];
                carry  = sum_s[DW];
                ovf    = (a[DW-1] == b[DW-1]) && (sum_s[DW-1] != a[DW-1]);
            end
            OP_SUB: begin
                result = diff_s;
                ovf    = (a[DW-1] != b[DW-1]) && (diff_s[DW-1] != a[DW-1]);
            end
            OP_MUL: begin
                result = prod_s[DW-1:0];
                hi     = prod_s[2*DW-1:DW];
            end
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_NOT:  result = ~b;
            default: result = {DW{1'b0}};
        endcase
        sign = (op == OP_MUL) ? hi[DW-1] : result[DW-1];
        zero = (op == OP_MUL) ? (prod_s == {(2*DW){1'b0}}) : (result == {DW{1'b0}});
    end
endmodule

// File: rtl/proc_fsm_core.sv
// Three-cycle-per-instruction processor core (FETCH/EXEC/NEXT) with loadable
// instruction memory, GPR file, data memory and a din/dout stream.
module proc_fsm_core
    import proc_pkg::*;
#(
    parameter int DW         = 16,
    parameter int NREG       = 32,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          sys_rst_n,
    input  logic                          start,
    proc_fsm_core_if.slave                bus,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc,
    output logic                          halted,
    output logic                          sign_f,
    output logic                          zero_f,
    output logic                          carry_f,
    output logic                          ovf_f
);
    localparam int PW = $clog2(IMEM_DEPTH);
    localparam int AW = $clog2(DMEM_DEPTH);

    state_t state_r, state_next_s;

    logic [31:0]   imem [IMEM_DEPTH];
    logic [DW-1:0] gpr  [NREG];
    logic [DW-1:0] dmem [DMEM_DEPTH];

    logic [31:0]   ir_r;
    logic [PW-1:0] pc_r;
    logic          taken_r;
    logic [DW-1:0] sgpr_r;
    logic          sign_r, zero_r, carry_r, ovf_r;
    logic [DW-1:0] dout_r;
    logic          dout_valid_r;
    logic          halted_r;

    logic [4:0]    op_s, rdst_s, rsrc1_s, rsrc2_s;
    logic          imm_s;
    logic [15:0]   isrc_s;
    logic [AW-1:0] daddr_s;
    logic [DW-1:0] a_s, b_s;
    logic          exec_s, start_ok_s;

    logic          gpr_we_s, dmem_we_s, flags_we_s, sgpr_we_s, send_s, taken_s;
    logic [DW-1:0] gpr_wdata_s, dmem_wdata_s;

    logic [DW-1:0] alu_result_s, alu_hi_s;
    logic          alu_sign_s, alu_zero_s, alu_carry_s, alu_ovf_s;

    assign op_s       = ir_op(ir_r);
    assign rdst_s     = ir_rdst(ir_r);
    assign rsrc1_s    = ir_rsrc1(ir_r);
    assign rsrc2_s    = ir_rsrc2(ir_r);
    assign imm_s      = ir_imm(ir_r);
    assign isrc_s     = ir_isrc(ir_r);
    assign daddr_s    = isrc_s[AW-1:0];
    assign exec_s     = (state_r == S_EXEC);
    assign start_ok_s = start && ((state_r == S_IDLE) || (state_r == S_HALTED));

    // mov and not take their single operand from rsrc1 when not immediate
    assign a_s = gpr[rsrc1_s];
    assign b_s = imm_s ? DW'(isrc_s)
               : (((op_s == OP_MOV) || (op_s == OP_NOT)) ? gpr[rsrc1_s] : gpr[rsrc2_s]);

    proc_alu #(.DW(DW)) u_alu (
        .op     (op_s),
        .a      (a_s),
        .b      (b_s),
        .result (alu_result_s),
        .hi     (alu_hi_s),
        .sign   (alu_sign_s),
        .zero   (alu_zero_s),
        .carry  (alu_carry_s),
        .ovf    (alu_ovf_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_r <= S_IDLE;
        else            state_r <= state_next_s;
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE:   state_next_s = start ? S_FETCH : S_IDLE;
            S_FETCH:  state_next_s = S_EXEC;
            S_EXEC:   state_next_s = (op_s == OP_HALT) ? S_HALTED : S_NEXT;
            S_NEXT:   state_next_s = S_FETCH;
            S_HALTED: state_next_s = start ? S_FETCH : S_HALTED;
            default:  state_next_s = S_IDLE;
        endcase
    end

    // FSM output decode: per-opcode EXEC strobes, qualified by exec_s at use
    always_comb begin
        gpr_we_s     = 1'b0;
        gpr_wdata_s  = alu_result_s;
        dmem_we_s    = 1'b0;
        dmem_wdata_s = gpr[rsrc1_s];
        flags_we_s   = 1'b0;
        sgpr_we_s    = 1'b0;
        send_s       = 1'b0;
        taken_s      = 1'b0;
        case (op_s)
            OP_MOVSGPR: begin
                gpr_we_s    = 1'b1;
                gpr_wdata_s = sgpr_r;
            end
            OP_MOV, OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR,
            OP_XNOR, OP_NAND, OP_NOR, OP_NOT: begin
                gpr_we_s   = 1'b1;
                flags_we_s = 1'b1;
                sgpr_we_s  = (op_s == OP_MUL);
            end
            OP_STOREREG: dmem_we_s = 1'b1;
            OP_STOREDIN: begin
                dmem_we_s    = 1'b1;
                dmem_wdata_s = bus.din;
            end
            OP_SENDDOUT: send_s = 1'b1;
            OP_LOADREG: begin
                gpr_we_s    = 1'b1;
                gpr_wdata_s = dmem[daddr_s];
            end
            OP_JUMP:        taken_s = 1'b1;
            OP_JCARRY:      taken_s = carry_r;
            OP_JNOCARRY:    taken_s = !carry_r;
            OP_JSIGN:       taken_s = sign_r;
            OP_JNOSIGN:     taken_s = !sign_r;
            OP_JZERO:       taken_s = zero_r;
            OP_JNOZERO:     taken_s = !zero_r;
            OP_JOVERFLOW:   taken_s = ovf_r;
            OP_JNOOVERFLOW: taken_s = !ovf_r;
            default:        taken_s = 1'b0;
        endcase
    end

    // Instruction memory write port; FETCH reads the pre-write word
    always_ff @(posedge clk) begin
        if (bus.imem_we) imem[bus.imem_waddr] <= bus.imem_wdata;
    end

    // GPR and data-memory writes; reset forces IDLE so nothing commits after it
    always_ff @(posedge clk) begin
        if (exec_s && gpr_we_s)  gpr[rdst_s]   <= gpr_wdata_s;
        if (exec_s && dmem_we_s) dmem[daddr_s] <= dmem_wdata_s;
    end

    // Sequencing registers: IR, PC and the registered branch decision
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ir_r    <= 32'h0000_0000;
            pc_r    <= {PW{1'b0}};
            taken_r <= 1'b0;
        end else begin
            if (state_r == S_FETCH) ir_r <= imem[pc_r];
            if (start_ok_s)              pc_r <= {PW{1'b0}};
            else if (state_r == S_NEXT)  pc_r <= taken_r ? isrc_s[PW-1:0] : pc_r + PW'(1'b1);
            taken_r <= exec_s && taken_s;
        end
    end

    // Architectural side state and registered outputs
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sgpr_r       <= {DW{1'b0}};
            sign_r       <= 1'b0;
            zero_r       <= 1'b0;
            carry_r      <= 1'b0;
            ovf_r        <= 1'b0;
            dout_r       <= {DW{1'b0}};
            dout_valid_r <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            if (exec_s && sgpr_we_s) sgpr_r <= alu_hi_s;
            if (exec_s && flags_we_s) begin
                sign_r  <= alu_sign_s;
                zero_r  <= alu_zero_s;
                carry_r <= alu_carry_s;
                ovf_r   <= alu_ovf_s;
            end
            if (exec_s && send_s) dout_r <= dmem[daddr_s];
            dout_valid_r <= exec_s && send_s;
            halted_r     <= (state_next_s == S_HALTED);
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign pc             = pc_r;
    assign halted         = halted_r;
    assign sign_f         = sign_r;
    assign zero_f         = zero_r;
    assign carry_f        = carry_r;
    assign ovf_f          = ovf_r;
endmodule

// File: doc/proc_fsm_core.md
Name: proc_fsm_core

Overview:
Parametrised successor to the team's single-issue 32-bit-instruction processor. An explicit state machine fetches, executes and retires one instruction every 3 cycles. Register count, data width and memory depths are parameters. All conditional jumps are implemented with real PC redirection, and halt/restart are supported. The instruction memory is loadable at run time through a write port, and the core sits between an external loader/host and a din/dout data stream.

Parameters:
DW, 16, datapath/GPR/data-memory width; legal range 16..32.
NREG, 32, number of GPRs; fixed at 32 by the 5-bit register fields.
IMEM_DEPTH, 16, instruction words; power of two.
DMEM_DEPTH, 16, data words; power of two.

Ports:
clk  in  1  core clock
sys_rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; leaves IDLE or HALTED and begins execution at PC 0
imem_we  in  1  instruction-memory write strobe
imem_waddr  in  $clog2(IMEM_DEPTH)  instruction write address
imem_wdata  in  32  instruction word
din  in  DW  external data input, sampled by storedin
dout  out  DW  external data output
dout_valid  out  1  one-cycle pulse when dout is updated
pc  out  $clog2(IMEM_DEPTH)  current program counter
halted  out  1  high while in HALTED
sign_f, zero_f, carry_f, ovf_f  out  1 each  condition flags

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=0, IR=0, SGPR=0, all flags=0, dout=0, dout_valid=0, halted=0.
- GPRs and data memory are not reset. Instruction memory is not reset.
- Instruction fields: op[31:27], rdst[26:22], rsrc1[21:17], imm[16], rsrc2[15:11], isrc[15:0].
- The immediate is zero-extended to DW.
- States: IDLE -start-> FETCH -> EXEC -> NEXT -> FETCH. Halt in EXEC goes to HALTED; start in HALTED resets pc to 0 and goes to FETCH.
- FETCH: IR <= imem[pc].
- EXEC: ALU result written to GPR[rdst]; memory/IO effects; flags updated; branch decision registered.
- NEXT: pc <= taken ? isrc[$clog2(IMEM_DEPTH)-1:0] : pc+1. pc wraps from IMEM_DEPTH-1 to 0.
- Cycles per instruction: 3.
- Operand B is isrc when imm=1, otherwise GPR[rsrc2]. For not and mov, the operand is isrc when imm=1, otherwise GPR[rsrc1].
- mul: full 2*DW-bit product. Low half goes to GPR[rdst], high half to SGPR. movsgpr copies SGPR into GPR[rdst].
- Flags are updated only by ALU ops (mov..not, mul); all other ops hold them.
  - sign = result MSB; for mul, SGPR MSB.
  - zero = result==0; for mul, the full product==0.
  - carry = bit DW of the (DW+1)-bit sum for add, 0 for other ALU ops.
  - overflow = signed overflow for add/sub (operand MSBs vs result MSB), 0 otherwise.
- Jumps test flags as left by the most recent ALU op. Only the low $clog2 bits of isrc form the target.
- Data memory:
  - storereg: dmem[isrc]=GPR[rsrc1].
  - storedin: dmem[isrc]=din, sampled in EXEC.
  - senddout: dout<=dmem[isrc], with dout_valid high for exactly the EXEC->NEXT edge cycle.
  - loadreg: GPR[rdst]=dmem[isrc].
  - dmem addresses use the low $clog2(DMEM_DEPTH) bits of isrc.
- Undefined opcodes execute as NOP: pc+1, no state change.
- An imem write during FETCH to the address being fetched: the core fetches the old word (read-before-write). Writes are legal in any state.
- Deasserting sys_rst_n mid-instruction aborts the instruction immediately; no partial GPR/dmem write completes after reset assertion.
- start outside IDLE/HALTED is ignored.

Decomposition:
- Shared package proc_pkg holds the opcode localparams and state enum. Opcode encodings:
  - ALU/move: movsgpr 00000, mov 00001, add 00010, sub 00011, mul 00100, or 00101, and 00110, xor 00111, xnor 01000, nand 01001, nor 01010, not 01011.
  - Memory/IO: storereg 01100, storedin 01101, senddout 01110, loadreg 01111.
  - Jumps: jump 10000, jcarry 10001, jnocarry 10010, jsign 10011, jnosign 10100, jzero 10101, jnozero 10110, joverflow 10111, jnooverflow 11000.
  - Control: halt 11011.
- Package also holds IR field-slice functions.
- One sub-module: proc_alu, combinational; inputs op/a/b; outputs result, hi, and the four flags.

Test Plan:
1. Load: mov r1,#5; add r2,r1,#0xFFFF; storereg [3]<-r2; senddout [3]; halt. -> dout=0x0004, dout_valid pulse, carry_f=1, halted=1 after 15 cycles from start.
2. mov r1,#0x7FFF; add r2,r1,#1; joverflow 6 -> ovf_f=1, sign_f=1, pc=6 after the jump's NEXT. Same with jnooverflow -> pc=3.
3. mov r1,#0x0100; mul r2,r1,#0x0100; movsgpr r3; storereg/senddout r3 -> dout=0x0001; r2 low half 0, zero_f=0.
4. din=0xA5A5; storedin [15]; loadreg r4,[15]; not r5,r4; storereg/senddout r5 -> dout=0x5A5A.
5. Program jump 15 at address 15; run 10 instructions -> pc stays 15. With address 15 = mov, pc wraps 15->0.
6. Drop sys_rst_n during EXEC of add -> destination GPR unchanged; pc=0, flags=0, state IDLE. Start after reset -> program reruns from 0.
